unit_task_scheduler: RTL and testbench
======================================

# unit_task_scheduler

Hands rasterization tasks from the object buffer to the parallel raster units. Picks idle units round-robin and tracks per-unit busy state. At end of frame it drains the units, waits for the depth comparator to finish writing, then raises the buffer-switch pulse. It sits between the object buffer, the `UNITS` raster units and the buffer switcher, and replaces the flat all-complete dispatch with per-unit scheduling.

## Interface
- `UNITS`, 16: number of raster units (2..16).
- `IDX_W`, 4: width of a unit index; must be ≥ clog2(UNITS).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse that begins a frame.
- `obj_valid`  in  1  object buffer has a task available.
- `obj_ready`  out  1  scheduler accepts the task this cycle.
- `read_end`  in  1  level: object buffer exhausted for this frame; held until the next `frame_start`.
- `unit_start`  out  UNITS  one-hot, one-cycle dispatch pulse to a unit.
- `dispatch_index`  out  IDX_W  index of the unit in the last dispatch.
- `unit_done`  in  UNITS  per-unit one-cycle completion pulses.
- `busy_mask`  out  UNITS  registered busy bit per unit.
- `depth_comparator_write_complete`  in  1  level: depth writes flushed.
- `task_count`  out  16  tasks dispatched in the current frame.
- `tasks_complete`  out  1  one-cycle pulse to the buffer switcher.

## Operation
- States: IDLE, DISPATCH, DRAIN, FLUSH. Reset puts the block in IDLE.
- On reset, every output is 0 and the round-robin pointer `rr` is 0.
- **IDLE**
  - `frame_start` clears `task_count` and moves to DISPATCH.
  - Other inputs are ignored.
  - `frame_start` in any state other than IDLE is ignored.
- **DISPATCH**
  - `obj_ready` = (state==DISPATCH) & ~&`busy_mask`.
  - Handshake = `obj_valid` & `obj_ready`.
  - On a handshake, the grant is the first unit with a clear registered busy bit, searching from `rr` upward and wrapping modulo UNITS.
  - The same edge sets that unit's busy bit, registers `unit_start` one-hot for that unit, sets `dispatch_index` to it, sets `rr` to (grant+1) mod UNITS, and increments `task_count`, saturating at 0xFFFF.
  - When `read_end` is high and there is no handshake this cycle, move to DRAIN.
  - When `read_end` and a handshake occur together, accept the object and stay in DISPATCH.
- **DRAIN**
  - `obj_ready` is 0.
  - When `busy_mask` is 0, move to FLUSH.
- **FLUSH**
  - When `depth_comparator_write_complete` is high, move to IDLE.
  - The same edge registers `tasks_complete` = 1 for exactly one cycle.
- **Busy tracking**
  - `unit_done[i]` clears `busy_mask[i]` at the next edge.
  - `unit_done` on a unit that is not busy is ignored.
  - Completion and grant in the same cycle: the grant uses the pre-edge mask, so a unit freed this cycle is eligible only from the next cycle.
  - Completion on unit i and a grant to unit j≠i in the same cycle both take effect.
- **Empty frame:** `read_end` already high at entry gives DISPATCH→DRAIN→FLUSH→IDLE, with `task_count` = 0 and one `tasks_complete` pulse.
- **Reset mid-frame:** immediately returns to IDLE with all outputs 0. In-flight units are forgotten (busy cleared).

## Timing
- `obj_ready` is combinational from state and `busy_mask` only, never from `obj_valid`.
- Handshake to `unit_start`: 1 cycle. Up to one dispatch per cycle; back-to-back dispatch is allowed.
- `unit_done` to busy bit clear: 1 cycle.
- Last `unit_done` (cycle t) to `tasks_complete`, with depth already complete: high in cycle t+3.
  - t+1: mask is 0 in DRAIN.
  - t+2: FLUSH.
  - t+3: pulse, state IDLE.
- `unit_start`, `tasks_complete`: single-cycle pulses. `dispatch_index` and `task_count` hold between updates.

## Test plan
- **Fill and stall:** UNITS=4, `obj_valid` held high, no `unit_done` → `unit_start` = 0001, 0010, 0100, 1000 on consecutive cycles; then `obj_ready` = 0 and `task_count` = 4.
- **Round-robin with free units:** units 0 and 2 free, `rr`=1 → grant unit 2 and `rr`=3; next handshake grants unit 0.
- **Done/grant collision:** all 4 busy, `unit_done[1]` and `obj_valid` in the same cycle → no grant that cycle; `unit_start` = 0010 one cycle later than that.
- **Frame close:** `read_end` high, last done in cycle t, `depth_comparator_write_complete` high → `tasks_complete` pulse only in cycle t+3. With write-complete held low for 5 cycles, the pulse is delayed 5 cycles.
- **Empty frame:** `frame_start` with `read_end` high → exactly one `tasks_complete` pulse, `task_count` = 0, no `unit_start`.
- **Reset mid-frame:** assert reset in DISPATCH with 3 units busy → `busy_mask`, `obj_ready`, `task_count` read 0 asynchronously; next `frame_start` dispatches unit 0 first.

Source files
------------

// File: rtl/unit_task_scheduler_if.sv
// unit_task_scheduler_if: handshake and status bundle between the object buffer, raster units and scheduler
interface unit_task_scheduler_if #(
    parameter int UNITS = 16,
    parameter int IDX_W = 4
);
    logic             frame_start;
    logic             obj_valid;
    logic             obj_ready;
    logic             read_end;
    logic [UNITS-1:0] unit_start;
    logic [IDX_W-1:0] dispatch_index;
    logic [UNITS-1:0] unit_done;
    logic [UNITS-1:0] busy_mask;
    logic             depth_comparator_write_complete;
    logic [15:0]      task_count;
    logic             tasks_complete;

    modport master (
        output frame_start, obj_valid, read_end, unit_done, depth_comparator_write_complete,
        input  obj_ready, unit_start, dispatch_index, busy_mask, task_count, tasks_complete
    );

    modport slave (
        input  frame_start, obj_valid, read_end, unit_done, depth_comparator_write_complete,
        output obj_ready, unit_start, dispatch_index, busy_mask, task_count, tasks_complete
    );
endinterface

// File: rtl/unit_task_scheduler.sv
// unit_task_scheduler: round-robin dispatch of raster tasks to idle units with end-of-frame drain and flush
module unit_task_scheduler #(
    parameter int UNITS = 16,
    parameter int IDX_W = 4
) (
    input logic                   clock,
    input logic                   reset,
    unit_task_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FLUSH} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] rr_q, rr_d, idx_q, grant;
    logic [UNITS-1:0] busy_q, busy_d, start_q, grant_oh;
    logic [15:0]      cnt_q, cnt_d;
    logic             done_q, hs;

    assign bus.obj_ready      = (state_q == DISPATCH) & ~&busy_q;
    assign bus.unit_start     = start_q;
    assign bus.dispatch_index = idx_q;
    assign bus.busy_mask      = busy_q;
    assign bus.task_count     = cnt_q;
    assign bus.tasks_complete = done_q;
    assign hs                 = bus.obj_valid & bus.obj_ready;

    // First idle unit at or above rr (wrapping), judged on the pre-edge busy mask
    always_comb begin
        grant = rr_q;
        for (int k = UNITS - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_q) + k) % UNITS;
            if (!busy_q[j]) grant = IDX_W'(j);
        end
        grant_oh = hs ? (UNITS'(1) << grant) : '0;
        busy_d   = (busy_q & ~bus.unit_done) | grant_oh;
        rr_d     = IDX_W'((int'(grant) + 1) % UNITS);
        cnt_d    = cnt_q + 16'(cnt_q != 16'hFFFF);
    end

    // Frame FSM with registered dispatch, busy tracking and completion pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            busy_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            start_q <= grant_oh;
            busy_q  <= busy_d;
            done_q  <= 1'b0;
            if (hs) begin
                idx_q <= grant;
                rr_q  <= rr_d;
                cnt_q <= cnt_d;
            end
            case (state_q)
                IDLE: if (bus.frame_start) begin
                    cnt_q   <= '0;
                    state_q <= DISPATCH;
                end
                DISPATCH: if (bus.read_end && !hs) state_q <= DRAIN;
                DRAIN: if (busy_q == '0) state_q <= FLUSH;
                FLUSH: if (bus.depth_comparator_write_complete) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unit_task_scheduler.sv
// tb_unit_task_scheduler: directed steps with a unit_start scoreboard for the task scheduler
module tb_unit_task_scheduler;
    localparam int U = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses;
    logic [U-1:0] sb[$];

    unit_task_scheduler_if #(.UNITS(U), .IDX_W(2)) bus ();

    unit_task_scheduler #(.UNITS(U), .IDX_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.unit_start != '0) begin
            if (sb.size() == 0) check("unexpected_unit_start", 32'(bus.unit_start), 32'd0);
            else check("unit_start", 32'(bus.unit_start), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.obj_valid = 1'b0;
        bus.read_end = 1'b0;
        bus.unit_done = '0;
        bus.depth_comparator_write_complete = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy_mask), 0);
        check("rst_ready", 32'(bus.obj_ready), 0);
        check("rst_count", 32'(bus.task_count), 0);
        check("rst_start", 32'(bus.unit_start), 0);
        check("rst_index", 32'(bus.dispatch_index), 0);
        check("rst_complete", 32'(bus.tasks_complete), 0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_ready", 32'(bus.obj_ready), 0);

        // fill and stall
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("dispatch_ready", 32'(bus.obj_ready), 1);
        bus.obj_valid = 1'b1;
        sb.push_back(4'b0001);
        sb.push_back(4'b0010);
        sb.push_back(4'b0100);
        sb.push_back(4'b1000);
        repeat (4) tick();
        check("fill_busy", 32'(bus.busy_mask), 32'hF);
        check("fill_ready", 32'(bus.obj_ready), 0);
        check("fill_count", 32'(bus.task_count), 4);
        check("fill_index", 32'(bus.dispatch_index), 3);
        tick();
        check("stall_start", 32'(bus.unit_start), 0);
        check("stall_count", 32'(bus.task_count), 4);

        // round-robin across free units
        bus.obj_valid = 1'b0;
        bus.unit_done = 4'b0001;
        tick();
        bus.unit_done = '0;
        check("done0_busy", 32'(bus.busy_mask), 32'hE);
        bus.obj_valid = 1'b1;
        sb.push_back(4'b0001);
        tick();
        bus.obj_valid = 1'b0;
        bus.unit_done = 4'b0101;
        tick();
        bus.unit_done = '0;
        check("free02_busy", 32'(bus.busy_mask), 32'hA);
        bus.obj_valid = 1'b1;
        sb.push_back(4'b0100);
        tick();
        check("rr_index2", 32'(bus.dispatch_index), 2);
        sb.push_back(4'b0001);
        tick();
        check("rr_index0", 32'(bus.dispatch_index), 0);
        check("rr_busy", 32'(bus.busy_mask), 32'hF);

        // done and request in the same cycle on a full mask
        bus.unit_done = 4'b0010;
        #1;
        check("collide_ready", 32'(bus.obj_ready), 0);
        tick();
        bus.unit_done = '0;
        check("collide_nostart", 32'(bus.unit_start), 0);
        check("collide_busy", 32'(bus.busy_mask), 32'hD);
        sb.push_back(4'b0010);
        tick();
        bus.obj_valid = 1'b0;
        check("collide_count", 32'(bus.task_count), 8);

        // frame close with depth already complete
        bus.read_end = 1'b1;
        bus.depth_comparator_write_complete = 1'b1;
        tick();
        check("drain_ready", 32'(bus.obj_ready), 0);
        bus.unit_done = 4'b1111;
        tick();
        bus.unit_done = '0;
        check("close_t1_busy", 32'(bus.busy_mask), 0);
        check("close_t1", 32'(bus.tasks_complete), 0);
        tick();
        check("close_t2", 32'(bus.tasks_complete), 0);
        tick();
        check("close_t3", 32'(bus.tasks_complete), 1);
        tick();
        check("close_t4", 32'(bus.tasks_complete), 0);

        // frame close with depth writes pending for five cycles
        bus.read_end = 1'b0;
        bus.depth_comparator_write_complete = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("frame2_count", 32'(bus.task_count), 0);
        bus.obj_valid = 1'b1;
        sb.push_back(4'b0100);
        tick();
        bus.obj_valid = 1'b0;
        bus.read_end = 1'b1;
        tick();
        bus.unit_done = 4'b0100;
        tick();
        bus.unit_done = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("delay_hold", 32'(bus.tasks_complete), 0);
        end
        bus.depth_comparator_write_complete = 1'b1;
        tick();
        check("delay_pulse", 32'(bus.tasks_complete), 1);
        tick();
        check("delay_after", 32'(bus.tasks_complete), 0);

        // empty frame
        pulses = 0;
        bus.frame_start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.frame_start = 1'b0;
            pulses += int'(bus.tasks_complete);
        end
        check("empty_pulses", 32'(pulses), 1);
        check("empty_count", 32'(bus.task_count), 0);

        // reset in the middle of a frame
        bus.read_end = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.obj_valid = 1'b1;
        sb.push_back(4'b1000);
        sb.push_back(4'b0001);
        sb.push_back(4'b0010);
        repeat (3) tick();
        bus.obj_valid = 1'b0;
        check("pre_reset_busy", 32'(bus.busy_mask), 32'hB);
        check("pre_reset_count", 32'(bus.task_count), 3);
        #3;
        reset = 1'b1;
        #1;
        check("async_busy", 32'(bus.busy_mask), 0);
        check("async_ready", 32'(bus.obj_ready), 0);
        check("async_count", 32'(bus.task_count), 0);
        tick();
        reset = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.obj_valid = 1'b1;
        sb.push_back(4'b0001);
        tick();
        bus.obj_valid = 1'b0;
        check("post_reset_index", 32'(bus.dispatch_index), 0);
        check("post_reset_busy", 32'(bus.busy_mask), 1);
        tick();
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
